// File: rtl/icache_rr_bin_arbiter.sv
// Round-robin pick of one requester as a binary index; 0-cycle request-to-index, pointer advances one edge after grant.
// Backpressure: gnt_i low locks the chosen index until a grant; gnt_i never feeds req_o/idx_o combinationally.
module icache_rr_bin_arbiter #(
    parameter int N_REQ     = 4,
    parameter int BIN_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_i,
    input  logic                 flush_i,
    input  logic                 gnt_i,
    output logic                 req_o,
    output logic [BIN_WIDTH-1:0] idx_o
);

    localparam logic [BIN_WIDTH-1:0] LAST_IDX = BIN_WIDTH'(N_REQ - 1);

    logic [BIN_WIDTH-1:0] rr_q;
    logic                 lock_q;
    logic [BIN_WIDTH-1:0] idx_q;

    logic                 search_hit;
    logic [BIN_WIDTH-1:0] search_idx;
    logic [BIN_WIDTH-1:0] winner;
    logic [BIN_WIDTH-1:0] rr_nxt;
    logic                 xfer;
    logic                 stall;

    // rr_q is always below N_REQ, so one subtraction is enough to wrap.
    always_comb begin
        int cand;
        search_hit = 1'b0;
        search_idx = '0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!search_hit && req_i[cand]) begin
                search_hit = 1'b1;
                search_idx = BIN_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        req_o  = lock_q | (|req_i);
        winner = lock_q ? idx_q : search_idx;
        idx_o  = req_o ? winner : '0;
        xfer   = req_o & gnt_i;
        stall  = req_o & ~gnt_i;
        rr_nxt = (idx_o == LAST_IDX) ? '0 : idx_o + BIN_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
            idx_q  <= '0;
        end else if (flush_i) begin
            rr_q   <= '0;
            lock_q <= 1'b0;
        end else if (xfer) begin
            rr_q   <= rr_nxt;
            lock_q <= 1'b0;
        end else if (stall) begin
            lock_q <= 1'b1;
            idx_q  <= idx_o;
        end
    end

endmodule

// File: tb/tb_icache_rr_bin_arbiter.sv
// Bench for icache_rr_bin_arbiter: a 4-requester and a 3-requester instance against a queue-free reference model.
module tb_icache_rr_bin_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] req4;
    logic       gnt4, flush4, reqo4;
    logic [1:0] idx4;
    logic [2:0] req3;
    logic       gnt3, flush3, reqo3;
    logic [1:0] idx3;

    int total = 0;
    int bad   = 0;

    // reference state per instance: next-priority requester, and held winner (-1 when none)
    int m_ptr [2];
    int m_held[2];

    icache_rr_bin_arbiter #(.N_REQ(4), .BIN_WIDTH(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_i(req4), .flush_i(flush4),
        .gnt_i(gnt4), .req_o(reqo4), .idx_o(idx4));

    icache_rr_bin_arbiter #(.N_REQ(3), .BIN_WIDTH(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .flush_i(flush3),
        .gnt_i(gnt3), .req_o(reqo3), .idx_o(idx3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // winner = requesting index at the smallest circular distance ahead of the pointer
    function automatic int pick(input int n, input int ptr, input logic [3:0] r);
        int best, bestd, d;
        best  = -1;
        bestd = n;
        for (int i = 0; i < n; i++) begin
            d = (i - ptr + n) % n;
            if (r[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic int m_reqo(input int s, input logic [3:0] r);
        return (m_held[s] >= 0 || r != 4'd0) ? 1 : 0;
    endfunction

    function automatic int m_idx(input int s, input int n, input logic [3:0] r);
        if (m_held[s] >= 0) return m_held[s];
        if (r == 4'd0)      return 0;
        return pick(n, m_ptr[s], r);
    endfunction

    task automatic m_update(input int s, input int n, input logic [3:0] r, input logic g, input logic f);
        int ro, w;
        ro = m_reqo(s, r);
        w  = m_idx(s, n, r);
        if (f) begin
            m_ptr[s]  = 0;
            m_held[s] = -1;
        end else if (ro == 1 && g) begin
            m_ptr[s]  = (w + 1) % n;
            m_held[s] = -1;
        end else if (ro == 1) begin
            m_held[s] = w;
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < 2; s++) begin
            m_ptr[s]  = 0;
            m_held[s] = -1;
        end
    endtask

    // one clock: drive after negedge, check just after, advance model at the posedge
    task automatic cyc(input logic [3:0] r4, input logic g4, input logic f4,
                       input logic [2:0] r3, input logic g3, input logic f3,
                       input int e4, input int e3, input string tag);
        @(negedge clk);
        req4 = r4; gnt4 = g4; flush4 = f4;
        req3 = r3; gnt3 = g3; flush3 = f3;
        #1;
        chk({tag, ".reqo4"}, reqo4, m_reqo(0, r4));
        chk({tag, ".idx4"},  idx4,  m_idx(0, 4, r4));
        chk({tag, ".reqo3"}, reqo3, m_reqo(1, {1'b0, r3}));
        chk({tag, ".idx3"},  idx3,  m_idx(1, 3, {1'b0, r3}));
        if (e4 >= 0) chk({tag, ".idx4_lit"}, idx4, e4);
        if (e3 >= 0) chk({tag, ".idx3_lit"}, idx3, e3);
        @(posedge clk);
        m_update(0, 4, r4, g4, f4);
        m_update(1, 3, {1'b0, r3}, g3, f3);
    endtask

    int         fair4[6] = '{0, 1, 2, 3, 0, 1};
    int         fair3[6] = '{0, 1, 2, 0, 1, 2};
    logic [3:0] pend4;
    logic [2:0] pend3;
    logic       g4r, f4r, g3r, f3r;
    int         w4, w3;

    initial begin
        rst_n = 1'b0;
        req4 = '0; gnt4 = 1'b0; flush4 = 1'b0;
        req3 = '0; gnt3 = 1'b0; flush3 = 1'b0;
        m_reset();
        #12;
        chk("rst.reqo4", reqo4, 0);
        chk("rst.idx4",  idx4,  0);
        chk("rst.idx3",  idx3,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // full load, both instances
        for (int i = 0; i < 6; i++)
            cyc(4'b1111, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, fair4[i], fair3[i], "fair");

        // sparse requests from a cleared pointer
        cyc(4'b0000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 0, -1, "sparse_flush");
        for (int i = 0; i < 4; i++)
            cyc(4'b1010, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, (i % 2 == 0) ? 1 : 3, -1, "sparse");

        // lock under stall, other requests arriving mid-stall
        cyc(4'b0110, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1, -1, "lock_s1");
        cyc(4'b0111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1, -1, "lock_s2");
        cyc(4'b0111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1, -1, "lock_s3");
        cyc(4'b0111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1, -1, "lock_gnt");
        cyc(4'b0101, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2, -1, "lock_next");
        cyc(4'b0001, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 0, -1, "lock_tail");

        // flush while locked on 2 with pointer at 2
        cyc(4'b0010, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1, -1, "fl_setup");
        cyc(4'b0100, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2, -1, "fl_lock");
        cyc(4'b0101, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 2, -1, "fl_cycle");
        cyc(4'b0101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0, -1, "fl_after");
        cyc(4'b0101, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 0, -1, "fl_gnt0");
        cyc(4'b0100, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2, -1, "fl_gnt2");

        // asynchronous reset mid-stall
        cyc(4'b0010, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1, -1, "rs_setup");
        cyc(4'b0100, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2, -1, "rs_lock");
        @(negedge clk);
        req4 = 4'b0101; gnt4 = 1'b0;
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("rs_mid.idx4",  idx4,  0);
        chk("rs_mid.reqo4", reqo4, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0101, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 0, -1, "rs_rel0");
        cyc(4'b0100, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2, -1, "rs_rel2");

        // idle with gnt toggling: state must hold (pointer stays at 3)
        for (int i = 0; i < 5; i++)
            cyc(4'b0000, 1'(i % 2), 1'b0, 3'b000, 1'(i % 2), 1'b0, 0, 0, "idle");
        cyc(4'b1111, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3, -1, "idle_next");

        // random traffic; a requester drops its bit only once granted
        pend4 = '0;
        pend3 = '0;
        for (int i = 0; i < 400; i++) begin
            pend4 = pend4 | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            pend3 = pend3 | 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            g4r = 1'($urandom_range(0, 1));
            g3r = 1'($urandom_range(0, 1));
            f4r = ($urandom_range(0, 15) == 0);
            f3r = ($urandom_range(0, 15) == 0);
            w4 = m_idx(0, 4, pend4);
            w3 = m_idx(1, 3, {1'b0, pend3});
            cyc(pend4, g4r, f4r, pend3, g3r, f3r, -1, -1, "rand");
            if (g4r && !f4r && pend4 != 4'd0 && $urandom_range(0, 3) != 0) pend4[w4] = 1'b0;
            if (g3r && !f3r && pend3 != 3'd0 && $urandom_range(0, 3) != 0) pend3[w3] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_rr_bin_arbiter.md
# icache_rr_bin_arbiter

Round-robin arbiter for the instruction-cache interconnect. It picks one of N_REQ requesters and presents the winner as a binary index. That index drives the binary-to-one-hot decoder immediately downstream, which fans the grant back out to the requesters. The block keeps a registered priority pointer and locks the selected index while a request is stalled, so the downstream decoder sees a stable index until the transfer completes.

## Interface
Parameters:
- N_REQ, default 4: number of requesters; must be 2 or more.
- BIN_WIDTH, default 2: width of the index; must satisfy N_REQ <= 2**BIN_WIDTH.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- req_i, input, N_REQ: per-requester request, one bit each.
- flush_i, input, 1: synchronous clear of the pointer and lock.
- gnt_i, input, 1: downstream accept of the current request.
- req_o, input-to-output combinational, 1: at least one request is being presented.
- idx_o, output, BIN_WIDTH: binary index of the selected requester.

## Operation
State registers:
- rr_q (BIN_WIDTH): priority pointer.
- lock_q (1): lock flag.
- idx_q (BIN_WIDTH): locked index.

Reset (rst_n low): rr_q=0, lock_q=0, idx_q=0, applied immediately and asynchronously.

Selection (combinational):
- Unlocked: search req_i starting at index rr_q, ascending, wrapping from N_REQ-1 to 0. The first set bit wins.
- Locked: the winner is idx_q.
- req_o = lock_q | (|req_i).
- idx_o = winner when req_o=1, else 0.
- Indices N_REQ to 2**BIN_WIDTH-1 are never produced.

Handshake: a transfer completes in a cycle where req_o=1 and gnt_i=1.
- On a transfer: rr_q <= (idx_o==N_REQ-1) ? 0 : idx_o+1, and lock_q <= 0.
- req_o=1 and gnt_i=0 (stall): lock_q <= 1 and idx_q <= idx_o. rr_q is unchanged.
- req_o=0: all state holds.

Requester rule: a requester must hold its req_i bit high until it is granted. While locked, changes on the other req_i bits do not affect idx_o.

Flush:
- flush_i=1 forces rr_q <= 0 and lock_q <= 0 at the next edge, overriding any transfer or stall update that cycle.
- idx_o in the flush cycle is still computed from the current state.

Simultaneous events:
- A transfer and newly arriving requests in the same cycle: the new requests take part in the next cycle's search, using the updated rr_q.
- A transfer on the first cycle of a request (gnt_i=1 immediately): lock_q never sets.

## Timing
- Request to selection: 0 cycles. req_o and idx_o follow req_i combinationally when unlocked.
- Pointer advance: one edge after the transfer. The next winner is visible in the following cycle.
- Throughput: one transfer per cycle with gnt_i held high.
- Reset release: first selection in the cycle after rst_n rises, using rr_q=0.
- Asynchronous reset mid-stall: the lock is dropped immediately and the pointer returns to 0. idx_o changes combinationally within the reset cycle.
- No combinational path from gnt_i to idx_o or req_o. gnt_i affects only state.

## Test plan
- Fairness, full load: N_REQ=4, req_i=4'b1111 and gnt_i=1 held, after reset. Required: idx_o = 0,1,2,3,0,1 on successive cycles, req_o=1 throughout.
- Sparse requests: req_i=4'b1010, gnt_i=1. Required: idx_o = 1,3,1,3. Indices 0 and 2 never appear.
- Lock under stall: req_i=4'b0110, gnt_i=0 for 3 cycles, with req_i changed to 4'b0111 in stall cycle 2; then gnt_i=1. Required: idx_o=1 through all stall cycles and the grant cycle, then idx_o=2 on the next cycle.
- Non-power-of-two wrap: N_REQ=3, BIN_WIDTH=2, req_i=3'b111, gnt_i=1. Required: idx_o = 0,1,2,0. Index 3 is never produced.
- Flush and reset mid-operation:
  - Flush: lock on idx 2 with rr_q=2, then flush_i=1 for one cycle with req_i=4'b0101. Required: next cycle idx_o=0.
  - Reset: repeat the locked setup, then assert rst_n=0 asynchronously mid-cycle. Required: idx_o=0 immediately for req_i=4'b0101, and after release the selection starts from 0.
- Idle: req_i=0 for 5 cycles with gnt_i toggling. Required: req_o=0, idx_o=0, and rr_q unchanged, checked by the next selection with req_i=4'b1111 giving the expected index.
